load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-002 rst_i  in  1  reset; synchronous, active-high.
REQ-003 ld_req_i  in  1  load request; sampled in IDLE only.
REQ-004 st_req_i  in  1  store request; sampled in IDLE only.
REQ-005 funct3_i  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
REQ-006 addr_i  in  32  byte address computed by the ALU.
REQ-007 wdata_i  in  32  store data from rs2.
REQ-008 mem_req_o  out  1  memory request; held until mem_gnt_i.
REQ-009 mem_we_o  out  1  1 = store, 0 = load.
REQ-010 mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-011 mem_be_o  out  4  byte enables.
REQ-012 mem_wdata_o  out  32  lane-replicated store data.
REQ-013 mem_gnt_i  in  1  request accepted.
REQ-014 mem_rvalid_i  in  1  read data valid.
REQ-015 mem_rdata_i  in  32  raw read word.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 done_o  out  1  one-cycle completion pulse.
REQ-018 rdata_o  out  32  extended load result; held until the next load completes.
REQ-019 err_o  out  1  one-cycle pulse on misaligned access, illegal funct3, or timeout; coincides with done_o.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT_R, DONE and ERR.
REQ-021 In IDLE, a request SHALL latch addr_i, funct3_i, wdata_i and the direction.
- Legal request -> REQ.
- Illegal funct3 or misaligned request -> ERR.
REQ-022 Misaligned SHALL mean: H/HU with addr[0]=1, or W with addr[1:0]!=00.
REQ-023 If ld_req_i and st_req_i are both high, the load SHALL win and the store SHALL be dropped.
REQ-024 Requests outside IDLE SHALL be ignored.
REQ-025 In REQ, mem_req_o SHALL be 1.
- mem_gnt_i with store -> DONE.
- mem_gnt_i with load -> WAIT_R.
- No mem_gnt_i -> stay in REQ.
REQ-026 In WAIT_R, mem_rvalid_i SHALL capture the extended data into rdata_o and move to DONE.
- rvalid in the grant cycle SHALL be ignored.
REQ-027 DONE SHALL assert done_o for one cycle and then go to IDLE.
REQ-028 ERR SHALL assert done_o and err_o for one cycle, SHALL issue no memory request, and SHALL then go to IDLE.
REQ-029 Byte enables SHALL be:
- B: 0001<<addr[1:0]
- H: 0011<<{addr[1],1'b0}
- W: 1111
- Loads use the same enables.
REQ-030 mem_wdata_o SHALL replicate the data across lanes:
- B: byte replicated x4
- H: halfword replicated x2
- W: unchanged
REQ-031 Load extraction SHALL select the byte or halfword at addr[1:0] (or {addr[1],0}).
- B and H are sign-extended; BU and HU are zero-extended; W passes through.
REQ-032 Minimum latency from request to done_o SHALL be 2 cycles for a store and 3 cycles for a load (grant in the first REQ cycle, rvalid in the next cycle).
REQ-033 mem_addr_o, mem_be_o, mem_we_o and mem_wdata_o SHALL be stable while mem_req_o=1.

Reset
REQ-034 On rst_i=1 at a clock edge: state=IDLE; mem_req_o=0, busy_o=0, done_o=0, err_o=0, rdata_o=0; latched registers cleared.
REQ-035 Reset mid-transaction SHALL drop mem_req_o in the next cycle.
- An rvalid arriving after reset SHALL be ignored.

Configuration
REQ-036 Macro LSU_TIMEOUT_EN SHALL select the timeout feature.
- Defined: a 4-bit watchdog counts cycles spent in REQ or WAIT_R. It clears on entry to REQ and on each transition. Reaching 15 SHALL abort to ERR with mem_req_o=0.
- Undefined: no counter; REQ and WAIT_R wait indefinitely.

Verification
REQ-037 LW addr=0x100, gnt in the first cycle, rvalid next with rdata=0xDEADBEEF -> rdata_o=0xDEADBEEF, done_o 3 cycles after the request, err_o=0.
REQ-038 LB addr=0x103, rdata=0x80FF_FFFF -> be=1000, rdata_o=0xFFFFFF80; the same access as LBU -> rdata_o=0x00000080.
REQ-039 SH addr=0x22, wdata=0x1234ABCD, gnt delayed 3 cycles -> mem_req_o held 4 cycles, be=1100, mem_wdata_o=0xABCDABCD, then done_o.
REQ-040 LW addr=0x101 -> no mem_req_o; done_o=err_o=1 one cycle later. funct3=011 gives the same response.
REQ-041 ld_req_i and st_req_i together -> load performed (mem_we_o=0). rst_i asserted in WAIT_R -> IDLE, and a later rvalid leaves rdata_o=0.
REQ-042 With LSU_TIMEOUT_EN, gnt never arrives -> err_o pulse after 15 REQ cycles, busy_o then 0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core/memory handshake bundle for the load/store unit.
// The slave modport is the LSU's view; the master modport is the core plus memory side.
interface load_store_unit_if;
   logic        ld_req_i;
   logic        st_req_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport slave (
      input  ld_req_i, st_req_i, funct3_i, addr_i, wdata_i,
             mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
             busy_o, done_o, rdata_o, err_o
   );

   modport master (
      output ld_req_i, st_req_i, funct3_i, addr_i, wdata_i,
             mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
             busy_o, done_o, rdata_o, err_o
   );
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store unit: byte/half/word access, lane replication and load extension.
// Define LSU_TIMEOUT_EN to add a 4-bit watchdog that aborts stalled REQ/WAIT_R to ERR.
module load_store_unit (
   input  logic               clk_i,
   input  logic               rst_i,
   load_store_unit_if.slave   bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT_R, DONE, ERR} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        mem_req_q, mem_req_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
`ifdef LSU_TIMEOUT_EN
   localparam logic [3:0] TMO_LAST = 4'd14;  // 15th waiting cycle aborts
   logic [3:0]  tmo_q, tmo_d;
`endif

   logic        illegal, misaligned;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_ext;

   always_comb begin
      illegal    = (bus.funct3_i == 3'b011) || (bus.funct3_i[2:1] == 2'b11);
      misaligned = ((bus.funct3_i[1:0] == 2'b01) && bus.addr_i[0]) ||
                   ((bus.funct3_i[1:0] == 2'b10) && (bus.addr_i[1:0] != 2'b00));
   end

   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_sel = bus.mem_rdata_i[7:0];
         2'd1:    byte_sel = bus.mem_rdata_i[15:8];
         2'd2:    byte_sel = bus.mem_rdata_i[23:16];
         default: byte_sel = bus.mem_rdata_i[31:24];
      endcase
      half_sel = addr_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
      case (funct3_q)
         3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ld_ext = {24'h0, byte_sel};
         3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  ld_ext = {16'h0, half_sel};
         default: ld_ext = bus.mem_rdata_i;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      funct3_d = funct3_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
`ifdef LSU_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.ld_req_i || bus.st_req_i) begin
               addr_d   = bus.addr_i;
               funct3_d = bus.funct3_i;
               wdata_d  = bus.wdata_i;
               we_d     = !bus.ld_req_i;  // load wins a simultaneous request
               state_d  = (illegal || misaligned) ? ERR : REQ;
`ifdef LSU_TIMEOUT_EN
               tmo_d    = 4'd0;
`endif
            end
         end
         REQ: begin
            if (bus.mem_gnt_i) begin
               state_d = we_q ? DONE : WAIT_R;
`ifdef LSU_TIMEOUT_EN
               tmo_d   = 4'd0;
`endif
            end
`ifdef LSU_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) state_d = ERR;
            else tmo_d = tmo_q + 4'd1;
`endif
         end
         WAIT_R: begin
            if (bus.mem_rvalid_i) begin
               rdata_d = ld_ext;
               state_d = DONE;
`ifdef LSU_TIMEOUT_EN
               tmo_d   = 4'd0;
`endif
            end
`ifdef LSU_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) state_d = ERR;
            else tmo_d = tmo_q + 4'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
      // outputs are decoded from the next state so they appear registered
      mem_req_d = (state_d == REQ);
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE) || (state_d == ERR);
      err_d     = (state_d == ERR);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         funct3_q  <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         mem_req_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
`ifdef LSU_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         funct3_q  <= funct3_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         mem_req_q <= mem_req_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
`ifdef LSU_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   always_comb begin
      bus.mem_req_o  = mem_req_q;
      bus.mem_we_o   = we_q;
      bus.mem_addr_o = {addr_q[31:2], 2'b00};
      case (funct3_q[1:0])
         2'b00: begin
            bus.mem_be_o    = 4'b0001 << addr_q[1:0];
            bus.mem_wdata_o = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            bus.mem_be_o    = 4'b0011 << {addr_q[1], 1'b0};
            bus.mem_wdata_o = {2{wdata_q[15:0]}};
         end
         default: begin
            bus.mem_be_o    = 4'b1111;
            bus.mem_wdata_o = wdata_q;
         end
      endcase
      bus.busy_o  = busy_q;
      bus.done_o  = done_q;
      bus.err_o   = err_q;
      bus.rdata_o = rdata_q;
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, errors, arbitration, reset and timeout.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   load_store_unit_if bus ();

   load_store_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus.ld_req_i = 0; bus.st_req_i = 0; bus.funct3_i = 0; bus.addr_i = 0;
      bus.wdata_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst = 1; tick(); tick(); rst = 0;
      total++; if (bus.mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.mem_req_o); end
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
      total++; if ({bus.done_o, bus.err_o} !== 2'b00) begin bad++; $display("FAIL reset_done_err got=%b exp=00", {bus.done_o, bus.err_o}); end
      total++; if (bus.rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata_o); end
   endtask

   task automatic test_lw;
      bus.ld_req_i = 1; bus.funct3_i = 3'b010; bus.addr_i = 32'h100;
      tick(); bus.ld_req_i = 0;
      total++; if ({bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.done_o} !== 4'b1010) begin
         bad++; $display("FAIL lw_req req/we/busy/done got=%b exp=1010", {bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.done_o}); end
      total++; if ({bus.mem_addr_o, bus.mem_be_o} !== {32'h100, 4'b1111}) begin
         bad++; $display("FAIL lw_addr_be got=%h/%b exp=00000100/1111", bus.mem_addr_o, bus.mem_be_o); end
      bus.mem_gnt_i = 1; tick(); bus.mem_gnt_i = 0;
      total++; if ({bus.mem_req_o, bus.done_o} !== 2'b00) begin bad++; $display("FAIL lw_wait req/done got=%b exp=00", {bus.mem_req_o, bus.done_o}); end
      bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEADBEEF; tick(); bus.mem_rvalid_i = 0;
      total++; if ({bus.done_o, bus.err_o} !== 2'b10) begin bad++; $display("FAIL lw_done done/err got=%b exp=10", {bus.done_o, bus.err_o}); end
      total++; if (bus.rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", bus.rdata_o); end
      tick();
      total++; if ({bus.done_o, bus.busy_o} !== 2'b00) begin bad++; $display("FAIL lw_idle done/busy got=%b exp=00", {bus.done_o, bus.busy_o}); end
   endtask

   task automatic test_load_ext;
      logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000};
      logic [31:0] ad  [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101};
      logic [31:0] rd  [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h80011234, 32'h80017FFF, 32'h00007F00};
      logic [3:0]  be  [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0011, 4'b0010};
      logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h00007FFF, 32'h0000007F};
      for (int i = 0; i < 6; i++) begin
         bus.ld_req_i = 1; bus.funct3_i = f3[i]; bus.addr_i = ad[i];
         tick(); bus.ld_req_i = 0;
         total++; if (bus.mem_be_o !== be[i]) begin bad++; $display("FAIL ld_be[%0d] got=%b exp=%b", i, bus.mem_be_o, be[i]); end
         // rvalid together with the grant must be ignored
         bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h11111111;
         tick(); bus.mem_gnt_i = 0; bus.mem_rdata_i = rd[i];
         tick(); bus.mem_rvalid_i = 0;
         total++; if ({bus.done_o, bus.rdata_o} !== {1'b1, exp[i]}) begin
            bad++; $display("FAIL ld_ext[%0d] done/rdata got=%b/%h exp=1/%h", i, bus.done_o, bus.rdata_o, exp[i]); end
         tick();
      end
   endtask

   task automatic test_sh_delayed_gnt;
      int good = 1;
      bus.st_req_i = 1; bus.funct3_i = 3'b001; bus.addr_i = 32'h22; bus.wdata_i = 32'h1234ABCD;
      tick(); bus.st_req_i = 0;
      // a request while busy must not disturb the latched access
      bus.ld_req_i = 1; bus.addr_i = 32'h500; bus.funct3_i = 3'b010;
      for (int i = 0; i < 3; i++) begin
         if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !==
             {1'b1, 1'b1, 4'b1100, 32'h20, 32'hABCDABCD}) good = 0;
         tick();
      end
      total++; if (good != 1) begin bad++; $display("FAIL sh_hold got=%b/%b/%h/%h exp=1/1100/00000020/abcdabcd",
         bus.mem_req_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o); end
      total++; if ({bus.mem_req_o, bus.done_o} !== 2'b10) begin bad++; $display("FAIL sh_req4 req/done got=%b exp=10", {bus.mem_req_o, bus.done_o}); end
      bus.ld_req_i = 0; bus.mem_gnt_i = 1; tick(); bus.mem_gnt_i = 0;
      total++; if ({bus.mem_req_o, bus.done_o, bus.err_o} !== 3'b010) begin
         bad++; $display("FAIL sh_done req/done/err got=%b exp=010", {bus.mem_req_o, bus.done_o, bus.err_o}); end
      tick();
      total++; if ({bus.done_o, bus.busy_o, bus.mem_req_o} !== 3'b000) begin
         bad++; $display("FAIL sh_idle got=%b exp=000", {bus.done_o, bus.busy_o, bus.mem_req_o}); end
   endtask

   task automatic test_sb_fast;
      bus.st_req_i = 1; bus.funct3_i = 3'b000; bus.addr_i = 32'h3; bus.wdata_i = 32'h123456A5;
      tick(); bus.st_req_i = 0;
      total++; if ({bus.mem_be_o, bus.mem_wdata_o} !== {4'b1000, 32'hA5A5A5A5}) begin
         bad++; $display("FAIL sb_lane got=%b/%h exp=1000/a5a5a5a5", bus.mem_be_o, bus.mem_wdata_o); end
      bus.mem_gnt_i = 1; tick(); bus.mem_gnt_i = 0;
      total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL sb_latency done got=%b exp=1", bus.done_o); end
      total++; if (bus.rdata_o !== 32'h7F) begin bad++; $display("FAIL sb_rdata_hold got=%h exp=0000007f", bus.rdata_o); end
      tick();
   endtask

   task automatic test_errors;
      logic        ld [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3 [4] = '{3'b010, 3'b011, 3'b001, 3'b010};
      logic [31:0] ad [4] = '{32'h101, 32'h100, 32'h21, 32'h102};
      for (int i = 0; i < 4; i++) begin
         bus.ld_req_i = ld[i]; bus.st_req_i = !ld[i]; bus.funct3_i = f3[i]; bus.addr_i = ad[i];
         tick(); bus.ld_req_i = 0; bus.st_req_i = 0;
         total++; if ({bus.mem_req_o, bus.done_o, bus.err_o, bus.busy_o} !== 4'b0111) begin
            bad++; $display("FAIL err[%0d] req/done/err/busy got=%b exp=0111", i, {bus.mem_req_o, bus.done_o, bus.err_o, bus.busy_o}); end
         tick();
         total++; if ({bus.mem_req_o, bus.done_o, bus.err_o, bus.busy_o} !== 4'b0000) begin
            bad++; $display("FAIL err_end[%0d] got=%b exp=0000", i, {bus.mem_req_o, bus.done_o, bus.err_o, bus.busy_o}); end
      end
      total++; if (bus.rdata_o !== 32'h7F) begin bad++; $display("FAIL err_rdata_hold got=%h exp=0000007f", bus.rdata_o); end
   endtask

   task automatic test_both_and_reset;
      bus.ld_req_i = 1; bus.st_req_i = 1; bus.funct3_i = 3'b010; bus.addr_i = 32'h40;
      tick(); bus.ld_req_i = 0; bus.st_req_i = 0;
      total++; if ({bus.mem_req_o, bus.mem_we_o} !== 2'b10) begin bad++; $display("FAIL both_we req/we got=%b exp=10", {bus.mem_req_o, bus.mem_we_o}); end
      bus.mem_gnt_i = 1; tick(); bus.mem_gnt_i = 0;
      rst = 1; tick(); rst = 0;
      total++; if ({bus.mem_req_o, bus.busy_o, bus.rdata_o} !== {2'b00, 32'h0}) begin
         bad++; $display("FAIL rst_mid req/busy/rdata got=%b/%b/%h exp=0/0/0", bus.mem_req_o, bus.busy_o, bus.rdata_o); end
      bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h12345678; tick(); bus.mem_rvalid_i = 0; tick();
      total++; if ({bus.done_o, bus.busy_o, bus.rdata_o} !== {2'b00, 32'h0}) begin
         bad++; $display("FAIL rst_late_rvalid done/busy/rdata got=%b/%b/%h exp=0/0/0", bus.done_o, bus.busy_o, bus.rdata_o); end
   endtask

   task automatic test_timeout;
      int n = 0;
      bus.ld_req_i = 1; bus.funct3_i = 3'b010; bus.addr_i = 32'h0;
      tick(); bus.ld_req_i = 0;
`ifdef LSU_TIMEOUT_EN
      while (bus.mem_req_o === 1'b1 && n < 40) begin n++; tick(); end
      total++; if (n != 15) begin bad++; $display("FAIL tmo_cycles got=%0d exp=15", n); end
      total++; if ({bus.mem_req_o, bus.done_o, bus.err_o} !== 3'b011) begin
         bad++; $display("FAIL tmo_err req/done/err got=%b exp=011", {bus.mem_req_o, bus.done_o, bus.err_o}); end
      tick();
      total++; if ({bus.busy_o, bus.err_o} !== 2'b00) begin bad++; $display("FAIL tmo_idle busy/err got=%b exp=00", {bus.busy_o, bus.err_o}); end
`else
      while (bus.mem_req_o === 1'b1 && bus.done_o === 1'b0 && n < 20) begin n++; tick(); end
      total++; if (n != 20) begin bad++; $display("FAIL notmo_wait got=%0d exp=20", n); end
      bus.mem_gnt_i = 1; tick(); bus.mem_gnt_i = 0;
      bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hCAFEF00D; tick(); bus.mem_rvalid_i = 0;
      total++; if ({bus.done_o, bus.err_o, bus.rdata_o} !== {2'b10, 32'hCAFEF00D}) begin
         bad++; $display("FAIL notmo_done done/err/rdata got=%b/%b/%h exp=1/0/cafef00d", bus.done_o, bus.err_o, bus.rdata_o); end
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_sh_delayed_gnt();
      test_sb_fast();
      test_errors();
      test_both_and_reset();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
